ocimem_access_arbiter: RTL and testbench

Shares the single-port on-chip debug memory (OCI RAM) of the Nios II debug core between two requesters: the Avalon debug_mem_slave port (CPU and system side) and the JTAG debug slave's sysclk-domain action strobes (`take_action_ocimem_a/b`, `jdo`). It arbitrates and sequences one access at a time. It maintains the JTAG auto-incrementing monitor address and data registers. It drives registered RAM controls with a fixed read latency.

---
 rtl/ocimem_access_arbiter.sv | 279 +++++++++++++++++++++++++++
 tb/tb_ocimem_access_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocimem_access_arbiter.sv
//------------------------------------------------------------------------------
// ocimem_access_arbiter
//
// Purpose:
//   Shares the single-port OCI debug RAM (256 x 32 by default) between two
//   requesters:
//   - the Avalon debug_mem_slave port (CPU/system side);
//   - the JTAG debug slave's sysclk-domain action strobes.
//   Only one access is in flight at a time.
//   The block also owns the JTAG monitor registers:
//   - MonAReg, an auto-incrementing address;
//   - MonDReg, the read-back data.
//   RAM controls are registered, so the RAM sees a clean, fixed-latency
//   interface.
//
// Ports:
//   clk, reset            - system clock; asynchronous active-high reset
//   av_address/read/write - Avalon request (read wins if both are high)
//   av_writedata          - Avalon write data
//   av_byteenable         - Avalon byte enables
//   av_readdata           - Avalon read data (valid while waitrequest is low)
//   av_waitrequest        - Avalon stall
//   take_action_ocimem_a  - JTAG strobe: load MonAReg from jdo, then read
//   take_action_ocimem_b  - JTAG strobe: write jdo[34:3] at MonAReg, then
//                           post-increment MonAReg
//   jdo                   - JTAG shifted data (address and write-data fields)
//   MonAReg, MonDReg      - JTAG monitor address and data
//   monitor_ready         - high when no JTAG access is outstanding
//   ram_addr/wren/byteenable/wdata - registered RAM controls
//   ram_rdata             - RAM read data, one cycle after ram_addr
//
// Configuration:
//   OCIMEM_ARB_ROUND_ROBIN_EN - when defined, contention is resolved
//   round-robin using a one-bit last_grant register. When undefined,
//   JTAG has fixed priority over Avalon.
//------------------------------------------------------------------------------
module ocimem_access_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int JDO_ADDR_LSB = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteenable,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_CAPTURE
  } state_t;

  state_t state;
  state_t state_nxt;

  // Pending JTAG slot: at most one outstanding JTAG request.
  logic        jt_pend_rd;
  logic        jt_pend_wr;
  logic [31:0] jt_wdata;

  // Attributes of the access currently in flight.
  logic cur_jtag;
  logic cur_read;

  logic [31:0] av_rdata_q;

  logic av_req;
  logic jt_pend;
  logic grant_jtag;
  logic grant_av;
  logic av_done;
  logic jt_done;
  logic jt_rd_done;

`ifdef OCIMEM_ARB_ROUND_ROBIN_EN
  // 0 = Avalon was granted last, 1 = JTAG was granted last.
  logic last_grant;
`endif

  // jdo carries fields this block does not use.
  // They are folded into one bit so they are not flagged as unused.
  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

  assign av_req  = av_read | av_write;
  assign jt_pend = jt_pend_rd | jt_pend_wr;

  assign av_waitrequest = av_req & ~av_done;

  // Avalon read data must be valid in the same cycle that waitrequest drops.
  // In CAPTURE, the RAM output is therefore passed straight through.
  // Outside CAPTURE, the last registered value is held.
  assign av_readdata = (state == ST_CAPTURE && !cur_jtag) ? ram_rdata : av_rdata_q;

  // State register for the access sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, grant selection and completion flags.
  // In IDLE, a winner is chosen among pending requests.
  // A write finishes in ACCESS; a read goes on to CAPTURE for its data.
  // Done flags are high for exactly the completing cycle.
  always_comb begin
    state_nxt  = state;
    grant_jtag = 1'b0;
    grant_av   = 1'b0;
    av_done    = 1'b0;
    jt_done    = 1'b0;
    jt_rd_done = 1'b0;
    case (state)
      ST_IDLE: begin
`ifdef OCIMEM_ARB_ROUND_ROBIN_EN
        if (jt_pend && (!av_req || last_grant == 1'b0)) begin
          grant_jtag = 1'b1;
        end else if (av_req) begin
          grant_av = 1'b1;
        end
`else
        if (jt_pend) begin
          grant_jtag = 1'b1;
        end else if (av_req) begin
          grant_av = 1'b1;
        end
`endif
        if (grant_jtag || grant_av) begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cur_read) begin
          state_nxt = ST_CAPTURE;
        end else begin
          state_nxt = ST_IDLE;
          if (cur_jtag) begin
            jt_done = 1'b1;
          end else begin
            av_done = 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        state_nxt = ST_IDLE;
        if (cur_jtag) begin
          jt_done    = 1'b1;
          jt_rd_done = 1'b1;
        end else begin
          av_done = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered RAM controls and in-flight attributes, loaded on a grant.
  // Write enable is a single-cycle pulse: it drops on every cycle that
  // is not a write grant. Address, byte enables and write data are held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr       <= '0;
      ram_wren       <= 1'b0;
      ram_byteenable <= 4'h0;
      ram_wdata      <= 32'h0;
      cur_jtag       <= 1'b0;
      cur_read       <= 1'b0;
    end else if (grant_jtag) begin
      ram_addr       <= MonAReg;
      ram_wren       <= jt_pend_wr & ~jt_pend_rd;
      ram_byteenable <= 4'hF;
      ram_wdata      <= jt_wdata;
      cur_jtag       <= 1'b1;
      cur_read       <= jt_pend_rd;
    end else if (grant_av) begin
      ram_addr       <= av_address;
      ram_wren       <= ~av_read;
      ram_byteenable <= av_byteenable;
      ram_wdata      <= av_writedata;
      cur_jtag       <= 1'b0;
      cur_read       <= av_read;
    end else begin
      ram_wren <= 1'b0;
    end
  end

  // JTAG pending slot.
  // A fresh strobe always overwrites whatever is waiting. Strobe a beats
  // strobe b in the same cycle. A strobe also beats the clear caused by a
  // grant in the same cycle, so a request arriving as the old one is taken
  // is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jt_pend_rd <= 1'b0;
      jt_pend_wr <= 1'b0;
      jt_wdata   <= 32'h0;
    end else if (take_action_ocimem_a) begin
      jt_pend_rd <= 1'b1;
      jt_pend_wr <= 1'b0;
    end else if (take_action_ocimem_b) begin
      jt_pend_rd <= 1'b0;
      jt_pend_wr <= 1'b1;
      jt_wdata   <= jdo[34:3];
    end else if (grant_jtag) begin
      jt_pend_rd <= 1'b0;
      jt_pend_wr <= 1'b0;
    end
  end

  // JTAG monitor registers.
  // Strobe a reloads the address; any strobe clears monitor_ready.
  // Every JTAG completion advances MonAReg, which wraps naturally at
  // 2^ADDR_W. Only reads update MonDReg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MonAReg       <= '0;
      MonDReg       <= 32'h0;
      monitor_ready <= 1'b1;
    end else begin
      if (take_action_ocimem_a) begin
        MonAReg <= jdo[JDO_ADDR_LSB +: ADDR_W];
      end else if (jt_done) begin
        MonAReg <= MonAReg + ADDR_W'(1);
      end
      if (jt_rd_done) begin
        MonDReg <= ram_rdata;
      end
      if (take_action_ocimem_a || take_action_ocimem_b) begin
        monitor_ready <= 1'b0;
      end else if (jt_done) begin
        monitor_ready <= 1'b1;
      end
    end
  end

  // Holds the last Avalon read result after the bypass cycle has passed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      av_rdata_q <= 32'h0;
    end else if (state == ST_CAPTURE && !cur_jtag) begin
      av_rdata_q <= ram_rdata;
    end
  end

`ifdef OCIMEM_ARB_ROUND_ROBIN_EN
  // Remembers which side won the last grant, so that on contention the
  // other side is chosen next time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b0;
    end else if (grant_jtag) begin
      last_grant <= 1'b1;
    end else if (grant_av) begin
      last_grant <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ocimem_access_arbiter.sv
//------------------------------------------------------------------------------
// tb_ocimem_access_arbiter
//
// Directed bench for ocimem_access_arbiter.
// It uses a behavioural single-port RAM with a one-cycle read latency.
// It exercises the following:
//   - Avalon write/read latency;
//   - JTAG read and write with auto-increment and wrap;
//   - partial byte enables;
//   - contention between Avalon and JTAG;
//   - reset in the middle of an access.
// Expected values are hand-computed.
//------------------------------------------------------------------------------
module tb_ocimem_access_arbiter;

  logic        clk;
  logic        reset;
  logic [7:0]  av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [37:0] jdo;
  logic [7:0]  MonAReg;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int tests;
  int failures;
  int wren_cnt;
  logic mem_clear;

  logic [31:0] mem [0:255];

  ocimem_access_arbiter #(.ADDR_W(8), .JDO_ADDR_LSB(17)) dut (
    .clk                  (clk),
    .reset                (reset),
    .av_address           (av_address),
    .av_read              (av_read),
    .av_write             (av_write),
    .av_writedata         (av_writedata),
    .av_byteenable        (av_byteenable),
    .av_readdata          (av_readdata),
    .av_waitrequest       (av_waitrequest),
    .take_action_ocimem_a (take_action_ocimem_a),
    .take_action_ocimem_b (take_action_ocimem_b),
    .jdo                  (jdo),
    .MonAReg              (MonAReg),
    .MonDReg              (MonDReg),
    .monitor_ready        (monitor_ready),
    .ram_addr             (ram_addr),
    .ram_wren             (ram_wren),
    .ram_byteenable       (ram_byteenable),
    .ram_wdata            (ram_wdata),
    .ram_rdata            (ram_rdata)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural OCI RAM: byte-enabled writes and a registered read port.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (ram_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_byteenable[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
    ram_rdata <= mem[ram_addr];
  end

  // Counts cycles with the RAM write enable high, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_wren) wren_cnt <= wren_cnt + 1;
  end

  // Overall time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One Avalon access. Call it at posedge+1.
  // It holds the request until waitrequest drops (bounded wait).
  // lat is the number of cycles after the request cycle; -1 means timeout.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                               input logic [3:0] be, output logic [31:0] rdata, output int lat);
    av_address    = addr;
    av_writedata  = data;
    av_byteenable = be;
    av_write      = wr;
    av_read       = ~wr;
    lat           = 0;
    @(negedge clk);
    while (av_waitrequest && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    if (av_waitrequest) lat = -1;
    rdata = av_readdata;
    if (wr) checkOutput("av_wr_wren_at_done", 32'(ram_wren), 32'd1);
    @(posedge clk);
    #1;
    av_read  = 1'b0;
    av_write = 1'b0;
  endtask

  // One JTAG strobe (a: load address/read, b: write). Call it at posedge+1.
  // n is the number of cycles from the pending bit setting until
  // monitor_ready returns; -1 means timeout.
  task automatic jtagStrobe(input logic is_b, input logic [7:0] addr, input logic [31:0] data,
                            output int n);
    logic [37:0] j;
    j = '0;
    if (is_b) j[34:3] = data;
    else j[17 +: 8] = addr;
    jdo = j;
    take_action_ocimem_a = ~is_b;
    take_action_ocimem_b = is_b;
    @(posedge clk);
    #1;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    checkOutput("jtag_ready_cleared", 32'(monitor_ready), 32'd0);
    n = 0;
    while (!monitor_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!monitor_ready) n = -1;
  endtask

  // Directed test sequence.
  initial begin
    logic [31:0] rd;
    int lat;
    int n;
    int w0;
    int av_wins;

    tests = 0;
    failures = 0;
    wren_cnt = 0;
    reset = 1'b1;
    mem_clear = 1'b1;
    av_address = '0;
    av_read = 1'b0;
    av_write = 1'b0;
    av_writedata = '0;
    av_byteenable = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    jdo = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_MonAReg", 32'(MonAReg), 32'h0);
    checkOutput("rst_MonDReg", MonDReg, 32'h0);
    checkOutput("rst_monitor_ready", 32'(monitor_ready), 32'd1);
    checkOutput("rst_ram_wren", 32'(ram_wren), 32'd0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'h0);
    checkOutput("rst_ram_byteenable", 32'(ram_byteenable), 32'h0);
    checkOutput("rst_ram_wdata", ram_wdata, 32'h0);
    checkOutput("rst_av_readdata", av_readdata, 32'h0);
    checkOutput("rst_av_waitrequest", 32'(av_waitrequest), 32'd0);
    reset = 1'b0;
    mem_clear = 1'b0;
    @(posedge clk);
    #1;

    // Avalon write then read: low waitrequest at +1 and +2.
    applyStimulus(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, rd, lat);
    checkOutput("av_wr_latency", 32'(lat), 32'd1);
    applyStimulus(1'b0, 8'h10, 32'h0, 4'hF, rd, lat);
    checkOutput("av_rd_latency", 32'(lat), 32'd2);
    checkOutput("av_rd_data", rd, 32'hDEADBEEF);
    applyStimulus(1'b1, 8'hFE, 32'hCAFEF00D, 4'hF, rd, lat);
    applyStimulus(1'b1, 8'h30, 32'h0BADC0DE, 4'hF, rd, lat);

    // JTAG read at 0x10: ready three cycles after pending, address advances.
    jtagStrobe(1'b0, 8'h10, 32'h0, n);
    checkOutput("jt_rd_cycles", 32'(n), 32'd3);
    checkOutput("jt_rd_MonDReg", MonDReg, 32'hDEADBEEF);
    checkOutput("jt_rd_MonAReg", 32'(MonAReg), 32'h11);

    // Place MonAReg at 0xFF with a read of 0xFE.
    jtagStrobe(1'b0, 8'hFE, 32'h0, n);
    checkOutput("jt_rd2_MonDReg", MonDReg, 32'hCAFEF00D);
    checkOutput("jt_rd2_MonAReg", 32'(MonAReg), 32'hFF);

    // JTAG write at 0xFF: one wren pulse, full byte enables, address wraps.
    w0 = wren_cnt;
    jtagStrobe(1'b1, 8'h0, 32'h12345678, n);
    checkOutput("jt_wr_cycles", 32'(n), 32'd2);
    checkOutput("jt_wr_MonAReg_wrap", 32'(MonAReg), 32'h00);
    checkOutput("jt_wr_MonDReg_kept", MonDReg, 32'hCAFEF00D);
    checkOutput("jt_wr_ram_addr", 32'(ram_addr), 32'hFF);
    checkOutput("jt_wr_byteenable", 32'(ram_byteenable), 32'hF);
    checkOutput("jt_wr_wren_pulses", 32'(wren_cnt - w0), 32'd1);
    applyStimulus(1'b0, 8'hFF, 32'h0, 4'hF, rd, lat);
    checkOutput("jt_wr_readback", rd, 32'h12345678);

    // Partial byte enables keep the upper half.
    applyStimulus(1'b1, 8'h20, 32'hFFFFFFFF, 4'hF, rd, lat);
    applyStimulus(1'b1, 8'h20, 32'h00000000, 4'h3, rd, lat);
    applyStimulus(1'b0, 8'h20, 32'h0, 4'hF, rd, lat);
    checkOutput("be_partial_readback", rd, 32'hFFFF0000);

    // Contention: an Avalon read is held while JTAG strobes arrive every cycle.
    av_wins = 0;
    for (int i = 0; i < 12; i++) begin
      jdo = '0;
      jdo[17 +: 8] = 8'h30;
      take_action_ocimem_a = 1'b1;
      #4;
      if (i > 0 && !av_waitrequest) av_wins++;
      @(posedge clk);
      #1;
      if (i == 0) begin
        av_address = 8'h10;
        av_read = 1'b1;
      end
    end
    take_action_ocimem_a = 1'b0;
`ifdef OCIMEM_ARB_ROUND_ROBIN_EN
    checkOutput("contention_av_served", 32'(av_wins > 0), 32'd1);
`else
    checkOutput("contention_av_starved", 32'(av_wins), 32'd0);
`endif
    lat = 0;
    @(negedge clk);
    while (av_waitrequest && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    checkOutput("contention_av_finished", 32'(av_waitrequest), 32'd0);
    checkOutput("contention_av_data", av_readdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    av_read = 1'b0;
    n = 0;
    while (!monitor_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("contention_jt_finished", 32'(monitor_ready), 32'd1);

    // Reset during ACCESS of a JTAG write.
    jtagStrobe(1'b0, 8'h40, 32'h0, n);
    checkOutput("pre_rst_MonAReg", 32'(MonAReg), 32'h41);
    jdo = '0;
    jdo[34:3] = 32'h55AA55AA;
    take_action_ocimem_b = 1'b1;
    @(posedge clk);
    #1;
    take_action_ocimem_b = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_wr_wren_high", 32'(ram_wren), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_wren_low", 32'(ram_wren), 32'd0);
    checkOutput("abort_monitor_ready", 32'(monitor_ready), 32'd1);
    checkOutput("abort_MonAReg", 32'(MonAReg), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_rst_MonAReg", 32'(MonAReg), 32'h0);
    checkOutput("post_rst_ready", 32'(monitor_ready), 32'd1);
    checkOutput("post_rst_wren", 32'(ram_wren), 32'd0);
    applyStimulus(1'b0, 8'h41, 32'h0, 4'hF, rd, lat);
    checkOutput("post_rst_ram_untouched", rd, 32'h0);
    checkOutput("post_rst_av_latency", 32'(lat), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
